// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle
// short-press, long-press and auto-repeat events, plus a registered held flag.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic enable,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_prev_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    // State, counter and registered outputs; btn_prev resets high so a
    // button held through reset is not mistaken for a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b1;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= btn_in;
            short_q    <= short_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    // Next-state and event decode; disable forces idle ahead of everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_in && !btn_prev_q) begin
                        state_d = PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS: begin
                    if (!btn_in) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!btn_in) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d == PRESS) || (state_d == HOLD);
    end

    assign short_press = short_q;
    assign long_press  = long_q;
    assign repeat_tick = repeat_q;
    assign held        = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with a per-cycle expected-output queue.
module tb_button_event_decoder;

    localparam int unsigned L = 8;
    localparam int unsigned R = 4;

    typedef struct packed {
        logic s;
        logic l;
        logic r;
        logic h;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic enable;
    logic short_press;
    logic long_press;
    logic repeat_tick;
    logic held;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    button_event_decoder #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .enable     (enable),
        .short_press(short_press),
        .long_press (long_press),
        .repeat_tick(repeat_tick),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".short"},  short_press, e.s);
        chk({tag, ".long"},   long_press,  e.l);
        chk({tag, ".repeat"}, repeat_tick, e.r);
        chk({tag, ".held"},   held,        e.h);
    endtask

    // One clock: drive inputs, queue expected outputs, compare after the edge.
    task automatic step(input string tag, input logic b, input logic en,
                        input logic es, input logic el, input logic er, input logic eh);
        exp_t e;
        @(negedge clk);
        btn_in = b;
        enable = en;
        e = '{s: es, l: el, r: er, h: eh};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            chk_all(tag, sb_q.pop_front());
        end
    endtask

    // n consecutive high samples from IDLE; armed=0 means no rise is recognised.
    task automatic press(input string tag, input int n, input logic armed);
        for (int i = 1; i <= n; i++) begin
            step(tag, 1'b1, 1'b1, 1'b0,
                 armed && (i == L),
                 armed && (i > L) && (((i - L) % R) == 0),
                 armed);
        end
    endtask

    // m low samples; first one carries the expected short_press.
    task automatic release_low(input string tag, input int m, input logic exp_short);
        for (int i = 1; i <= m; i++) begin
            step(tag, 1'b0, 1'b1, (i == 1) && exp_short, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        exp_t zero;
        zero   = '0;
        rst    = 1'b1;
        btn_in = 1'b0;
        enable = 1'b1;
        #1;
        chk_all("reset", zero);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: short press
        release_low("t1_idle", 2, 1'b0);
        press("t1_press", 3, 1'b1);
        release_low("t1_rel", 2, 1'b1);

        // 2: threshold boundary
        press("t2_press7", 7, 1'b1);
        release_low("t2_rel7", 2, 1'b1);
        press("t2_press8", 8, 1'b1);
        release_low("t2_rel8", 2, 1'b0);

        // 3: auto-repeat
        press("t3_press20", 20, 1'b1);
        release_low("t3_rel", 2, 1'b0);

        // 4: held through reset
        @(negedge clk);
        btn_in = 1'b1;
        rst    = 1'b1;
        #1;
        chk_all("t4_in_reset", zero);
        @(negedge clk);
        rst = 1'b0;
        press("t4_held", 30, 1'b0);
        release_low("t4_low", 2, 1'b0);
        press("t4_press", 2, 1'b1);
        release_low("t4_rel", 1, 1'b1);

        // 5: enable drop mid-press and re-enable while held
        press("t5_press", 4, 1'b1);
        step("t5_dis", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        press("t5_reen", 20, 1'b0);
        release_low("t5_low", 1, 1'b0);
        press("t5_press2", 3, 1'b1);
        release_low("t5_rel", 1, 1'b1);

        // 6: async reset in HOLD while repeat_tick is high
        press("t6_hold", 12, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("t6_async", zero);
        @(negedge clk);
        rst = 1'b0;
        press("t6_after", 10, 1'b0);
        release_low("t6_low", 1, 1'b0);
        press("t6_press", 3, 1'b1);
        release_low("t6_rel", 2, 1'b1);

        checks++;
        assert (sb_q.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drain: observed %0d expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the stabilised button level from the debouncer and turns it into single-cycle user events: short press, long press, and auto-repeat while held.
- Sits directly downstream of the debouncer, one instance per button.
- Its pulses drive the control FSMs (mode select, value increment), so those FSMs never see raw levels.
- Timing is in clk cycles; no internal prescaler.

Parameters:
- LONG_CYCLES, 50_000_000, consecutive high samples (including the first) that make a press "long"; must be >= 2.
- REPEAT_CYCLES, 10_000_000, high samples between successive repeat_tick pulses once long; must be >= 1.
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES) - 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- btn_in  input  1  debounced button level, synchronous to clk
- enable  input  1  1 = decode events; 0 = force idle and suppress all events
- short_press  output  1  one-cycle pulse: press released before reaching long threshold
- long_press  output  1  one-cycle pulse: press reached LONG_CYCLES samples
- repeat_tick  output  1  one-cycle pulse every REPEAT_CYCLES samples after long_press while still held
- held  output  1  level: press in progress (state PRESS or HOLD)

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered. Nothing is combinational from btn_in.
- Reset (async, immediate) sets:
  - state = IDLE, cnt = 0
  - short_press = long_press = repeat_tick = held = 0
  - btn_prev = 1, so a button held through reset is not a press.
- btn_prev <= btn_in on every clock edge, regardless of enable.
- Pulse outputs default to 0 every cycle unless set below.
- enable = 0 has priority over all transitions:
  - state <= IDLE, cnt <= 0, all pulses 0; held falls on the next edge.
- IDLE:
  - btn_in = 1 and btn_prev = 0 -> state PRESS, cnt <= 1.
  - Otherwise stay in IDLE.
- PRESS:
  - btn_in = 0 -> short_press <= 1, state IDLE.
  - btn_in = 1 and cnt == LONG_CYCLES-1 -> long_press <= 1, state HOLD, cnt <= 0.
  - btn_in = 1 otherwise -> cnt++.
- HOLD:
  - btn_in = 0 -> state IDLE, no pulse.
  - btn_in = 1 and cnt == REPEAT_CYCLES-1 -> repeat_tick <= 1, cnt <= 0.
  - btn_in = 1 otherwise -> cnt++.
- held = 1 exactly when state is PRESS or HOLD. It is a registered decode.
- Latency:
  - held rises one cycle after the first high sample.
  - short_press is asserted in the cycle after the edge that samples the first low.
  - long_press is asserted in the cycle after the edge that samples the LONG_CYCLES-th consecutive high.
  - The k-th repeat_tick follows the (LONG_CYCLES + k·REPEAT_CYCLES)-th high sample.
- Exclusivity:
  - At most one pulse per cycle.
  - short_press and long_press never both occur for the same press.
- Re-enable while the button is held produces no event until a release (btn_in = 0 sampled) followed by a new rise.
- A 1-cycle glitch high (high sample followed by low) yields a short_press. The debouncer upstream is responsible for filtering.
- cnt never exceeds max(LONG_CYCLES, REPEAT_CYCLES) - 1. No wrap-around is possible.

Test Plan:
1. Short press (LONG_CYCLES=8, REPEAT_CYCLES=4): btn_in high 3 cycles then low -> held high 3 cycles; exactly one short_press pulse one cycle after the first low sample; no long_press or repeat_tick.
2. Threshold boundary: high 7 cycles -> one short_press, no long_press. High exactly 8 cycles -> long_press one cycle after the 8th high sample; no short_press on release.
3. Auto-repeat: high 20 cycles -> long_press after sample 8; repeat_tick after samples 12, 16, 20 (3 pulses); release gives no pulse; held falls on the edge after the first low sample.
4. Held through reset: btn_in = 1 while rst deasserts, stays high 30 cycles -> no pulses. Then low 2 cycles, high 2 cycles, low -> one short_press.
5. Enable: drop enable at high sample 5 of a press -> held = 0 next cycle, no pulses. Re-enable while still held for 20 cycles -> nothing. Release, then press 3 cycles -> one short_press.
6. Async reset mid-HOLD: assert rst between clock edges during HOLD -> held and all pulses 0 immediately, without waiting for clk. After release of rst with btn_in still high -> no events until a new release and press.
